// File: rtl/d_register_pkg.sv
// d_register_pkg
//   Shared types, default sizing, and the write-enable qualifier for the
//   d_register_bank storage block.
//   Contents:
//     state_t    - controller states (ST_IDLE, ST_SWEEP)
//     DEF_WIDTH  - default data bits per word
//     DEF_DEPTH  - default number of words
//     wr_allowed - both active-low enables asserted and address in range
package d_register_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 16;

  // An out-of-range address must never alias onto a real word, so the
  // range check is part of the enable itself.
  function automatic logic wr_allowed(input logic        g1_n,
                                      input logic        g2_n,
                                      input int unsigned addr,
                                      input int unsigned depth);
    return (!g1_n && !g2_n && (addr < depth));
  endfunction

endpackage

// File: rtl/d_register_array.sv
// d_register_array
//   DEPTH x WIDTH storage with one write port and one registered read port.
//   Contents are never reset; only the write port can change them.
//   Ports:
//     CLK     in   clock, rising edge
//     we      in   write enable (already qualified by the caller)
//     waddr   in   write address
//     wdata   in   write data
//     raddr   in   read address; values >= DEPTH read as 0
//     rd_zero in   force the read register to 0 this edge
//     rdata   out  registered read data, write-first on address match
module d_register_array #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  input  logic             rd_zero,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             rd_in_range;

  assign rd_in_range = ({1'b0, raddr} < DEPTH_W);

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (rd_zero) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else if (rd_in_range) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/d_register_bank.sv
// d_register_bank
//   Bank of DEPTH words of WIDTH bits: gated write port, registered read
//   port with output disable, and a hardware clear-all sweep.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | user writes/reads; CLEAR=1 starts a sweep
//   ST_SWEEP | one word cleared per cycle from ptr 0 to DEPTH-1, BUSY=1
//
//   Ports:
//     CLK    in   clock, rising edge
//     CLR_n  in   synchronous active-low reset (array contents kept)
//     G1_n   in   write enable 1, active-low
//     G2_n   in   write enable 2, active-low
//     WADDR  in   write address
//     D      in   write data
//     RADDR  in   read address
//     M      in   output disable A, active-high
//     N      in   output disable B, active-high
//     CLEAR  in   start clear-all sweep (sampled in IDLE)
//     Q      out  registered read data, 0 while Q_OE=0
//     Q_OE   out  output enable for the pin wrapper
//     BUSY   out  clear sweep in progress
module d_register_bank
  import d_register_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             G1_n,
  input  logic             G2_n,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RADDR,
  input  logic             M,
  input  logic             N,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] Q,
  output logic             Q_OE,
  output logic             BUSY
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_t           state, state_d;
  logic [AW-1:0]    ptr, ptr_d;
  logic             q_oe_r;
  logic             user_we;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             rd_zero;
  logic [WIDTH-1:0] rdata;

  assign user_we = wr_allowed(G1_n, G2_n, 32'(WADDR), 32'(DEPTH));

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      q_oe_r <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      q_oe_r <= !(M || N);
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    mem_we    = 1'b0;
    mem_waddr = WADDR;
    mem_wdata = D;
    rd_zero   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CLEAR) begin
          // clear wins over a simultaneous user write
          state_d = ST_SWEEP;
          ptr_d   = '0;
          rd_zero = 1'b1;
        end else if (user_we) begin
          mem_we = 1'b1;
        end
      end
      ST_SWEEP: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
        rd_zero   = 1'b1;
        if (ptr == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
    // Reset aborts the sweep without touching the word at the current
    // pointer, so already-cleared words stay 0 and the rest keep data.
    if (!CLR_n) begin
      mem_we  = 1'b0;
      rd_zero = 1'b1;
    end
  end

  d_register_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK     (CLK),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr   (RADDR),
    .rd_zero (rd_zero),
    .rdata   (rdata)
  );

  assign Q    = q_oe_r ? rdata : '0;
  assign Q_OE = q_oe_r;
  assign BUSY = (state == ST_SWEEP);

endmodule

// File: tb/tb_d_register_bank.sv
module tb_d_register_bank;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic       clr_n, g1_n, g2_n, m, n, clear;
  logic [3:0] waddr, raddr, d;
  logic [3:0] q;
  logic       q_oe, busy;

  // DEPTH=10 instance
  logic       t_clr_n, t_g1_n, t_g2_n, t_m, t_n, t_clear;
  logic [3:0] t_waddr, t_raddr, t_d;
  logic [3:0] t_q;
  logic       t_q_oe, t_busy;

  int n_cmp = 0;
  int n_mis = 0;

  d_register_bank #(.WIDTH(4), .DEPTH(16)) dut (
    .CLK(clk), .CLR_n(clr_n), .G1_n(g1_n), .G2_n(g2_n), .WADDR(waddr),
    .D(d), .RADDR(raddr), .M(m), .N(n), .CLEAR(clear),
    .Q(q), .Q_OE(q_oe), .BUSY(busy)
  );

  d_register_bank #(.WIDTH(4), .DEPTH(10)) dut10 (
    .CLK(clk), .CLR_n(t_clr_n), .G1_n(t_g1_n), .G2_n(t_g2_n), .WADDR(t_waddr),
    .D(t_d), .RADDR(t_raddr), .M(t_m), .N(t_n), .CLEAR(t_clear),
    .Q(t_q), .Q_OE(t_q_oe), .BUSY(t_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr16(input logic [3:0] a, input logic [3:0] v);
    waddr = a; d = v; g1_n = 1'b0; g2_n = 1'b0;
    tick();
    g1_n = 1'b1; g2_n = 1'b1;
  endtask

  task automatic rd16(input string tag, input logic [3:0] a, input logic [3:0] exp);
    raddr = a;
    tick();
    check_val(tag, {28'd0, q}, {28'd0, exp});
  endtask

  task automatic wait_idle16(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    if (busy) check_val({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt;
    clr_n = 1'b0; g1_n = 1'b1; g2_n = 1'b1; m = 1'b0; n = 1'b0; clear = 1'b0;
    waddr = '0; raddr = '0; d = '0;
    t_clr_n = 1'b0; t_g1_n = 1'b1; t_g2_n = 1'b1; t_m = 1'b0; t_n = 1'b0;
    t_clear = 1'b0; t_waddr = '0; t_raddr = '0; t_d = '0;
    tick(); tick();
    check_val("rst_q", {28'd0, q}, 32'd0);
    check_val("rst_qoe", 32'(q_oe), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    clr_n = 1'b1; t_clr_n = 1'b1;

    // clear sweep length on DEPTH=16
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = 0;
    repeat (40) begin
      if (busy) cnt++;
      tick();
    end
    check_val("sweep_len16", 32'(cnt), 32'd16);
    for (int a = 0; a < 16; a++) rd16("clr_read", 4'(a), 4'h0);
    check_val("qoe_on", 32'(q_oe), 32'd1);

    // basic write/read, then write with G1_n high is blocked
    wr16(4'd3, 4'hA);
    rd16("wr3", 4'd3, 4'hA);
    check_val("wr3_qoe", 32'(q_oe), 32'd1);
    waddr = 4'd3; d = 4'h5; g1_n = 1'b1; g2_n = 1'b0;
    tick();
    g2_n = 1'b1;
    rd16("g1_block", 4'd3, 4'hA);
    waddr = 4'd3; d = 4'h5; g1_n = 1'b0; g2_n = 1'b1;
    tick();
    g1_n = 1'b1;
    rd16("g2_block", 4'd3, 4'hA);

    // write-first bypass and output disable
    raddr = 4'd5;
    wr16(4'd5, 4'h7);
    check_val("bypass", {28'd0, q}, 32'h7);
    m = 1'b1;
    tick();
    check_val("m_q", {28'd0, q}, 32'h0);
    check_val("m_qoe", 32'(q_oe), 32'd0);
    m = 1'b0;
    tick();
    check_val("m_off_q", {28'd0, q}, 32'h7);
    n = 1'b1;
    tick();
    check_val("n_qoe", 32'(q_oe), 32'd0);
    n = 1'b0;

    // write to addr 9 during sweep (after pointer passed 9) is ignored
    wr16(4'd9, 4'hB);
    rd16("pre9", 4'd9, 4'hB);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (12) tick();
    check_val("busy_mid", 32'(busy), 32'd1);
    check_val("q_busy", {28'd0, q}, 32'h0);
    wr16(4'd9, 4'hF);
    wait_idle16("sweep2");
    rd16("busy_wr9", 4'd9, 4'h0);

    // clear beats a simultaneous write; first non-BUSY cycle write accepted
    wr16(4'd2, 4'h1);
    waddr = 4'd2; d = 4'h9; g1_n = 1'b0; g2_n = 1'b0; clear = 1'b1;
    tick();
    g1_n = 1'b1; g2_n = 1'b1; clear = 1'b0;
    wait_idle16("sweep3");
    wr16(4'd4, 4'h6);
    rd16("first_idle_wr", 4'd4, 4'h6);
    rd16("clear_wins", 4'd2, 4'h0);

    // mid-sweep reset at pointer 6
    for (int a = 0; a < 16; a++) wr16(4'(a), 4'hC);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (6) tick();
    clr_n = 1'b0;
    tick();
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_q", {28'd0, q}, 32'h0);
    check_val("abort_qoe", 32'(q_oe), 32'd0);
    clr_n = 1'b1;
    for (int a = 0; a < 16; a++) rd16("abort_read", 4'(a), (a < 6) ? 4'h0 : 4'hC);

    // DEPTH=10 instance
    t_clear = 1'b1;
    tick();
    t_clear = 1'b0;
    cnt = 0;
    repeat (30) begin
      if (t_busy) cnt++;
      tick();
    end
    check_val("sweep_len10", 32'(cnt), 32'd10);
    t_waddr = 4'd2; t_d = 4'h3; t_g1_n = 1'b0; t_g2_n = 1'b0;
    tick();
    t_waddr = 4'd9; t_d = 4'hD;
    tick();
    t_waddr = 4'd12; t_d = 4'hE;
    tick();
    t_g1_n = 1'b1; t_g2_n = 1'b1;
    t_raddr = 4'd2;
    tick();
    check_val("d10_a2", {28'd0, t_q}, 32'h3);
    t_raddr = 4'd9;
    tick();
    check_val("d10_a9", {28'd0, t_q}, 32'hD);
    t_raddr = 4'd12;
    tick();
    check_val("d10_a12", {28'd0, t_q}, 32'h0);
    t_raddr = 4'd4;
    tick();
    check_val("d10_a4", {28'd0, t_q}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
